l1_axi_responder: RTL
=====================

// Module: l1_axi_responder
// PURPOSE
//  AXI4-subset responder (slave) backing a 32-bit word memory; the target end of an app core's m_axi_l1 port.
//  Serves INCR read bursts (ARLEN 0..255) and write bursts with byte strobes. Produces B/R responses with echoed IDs.
//  Used as the L1/memory model behind task cores in unit and cluster benches. Bench preload via a backdoor port.
// PARAMETERS
//  MEM_WORDS   4096  memory depth in 32-bit words (power of 2)
//  ID_WIDTH    1     width of AWID/ARID/BID/RID
// PORTS
//  clk             in   1          clock
//  rstn            in   1          sync active-low reset
//  s_awvalid/awready  in/out 1     write-address handshake
//  s_awaddr        in   32         byte address of first write beat
//  s_awlen         in   8          beats-1
//  s_awsize        in   3          must be 3'b010
//  s_awid          in   ID_WIDTH   write ID, echoed on s_bid
//  s_wvalid/wready in/out 1        write-data handshake
//  s_wdata         in   32         write data
//  s_wstrb         in   4          byte enables
//  s_wlast         in   1          last write beat
//  s_bvalid/bready out/in 1        write-response handshake
//  s_bresp         out  2          00 OKAY, 10 SLVERR
//  s_bid           out  ID_WIDTH   echoed AWID
//  s_arvalid/arready  in/out 1     read-address handshake
//  s_araddr        in   32         byte address of first read beat
//  s_arlen         in   8          beats-1
//  s_arsize        in   3          must be 3'b010
//  s_arid          in   ID_WIDTH   read ID, echoed on s_rid
//  s_rvalid/rready out/in 1        read-data handshake
//  s_rdata         out  32         read data
//  s_rlast         out  1          last read beat
//  s_rresp         out  2          per-beat OKAY/SLVERR
//  s_rid           out  ID_WIDTH   echoed ARID
//  bd_we           in   1          backdoor write enable (bench preload)
//  bd_addr/bd_data in   log2(MEM_WORDS)/32  backdoor word index/data
// BEHAVIOUR
//  Reset: bvalid=rvalid=0; rlast=0; bresp=rresp=00; both FSMs idle; arready=1, awready=wready gated as below. Memory not cleared.
//  Word index = addr[31:2]; beat k of a burst uses index+k. Index >= MEM_WORDS, or size!=3'b010 -> that beat SLVERR.
//   SLVERR read beat returns 0; SLVERR write beat does not modify memory. No wrap: burst crossing the end errors from that beat on.
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   W_IDLE: awready=wready=(awvalid & wvalid & !bd_we); AW and first W beat are taken in the SAME cycle (initiators hold both
//   valids until both readies). Latch id, next index, error. wlast -> W_RESP, else W_DATA.
//   W_DATA: wready=!bd_we, awready=0; each beat writes with strobes, index++; beat with wlast -> W_RESP.
//   W_RESP: bvalid=1, bresp=OR of beat errors, bid=latched id; bready -> W_IDLE. Next AW accepted earliest the cycle after.
//   wlast early/late vs awlen: burst ends on wlast; mismatch sets SLVERR in bresp.
//  Read FSM R_IDLE -> R_FETCH -> R_DATA:
//   R_IDLE: arready=1; on arvalid latch addr/len/id -> R_FETCH. R_FETCH: issue memory read (1-cycle sync) -> R_DATA.
//   R_DATA: rvalid=1; rdata/rresp held stable while !rready. On rvalid&rready&!rlast issue next read same cycle
//   (sustained 1 beat/cycle). rlast=1 on beat count==len; handshake of last beat -> R_IDLE.
//   Latency: AR handshake cycle T -> first rvalid at T+2.
//  Read/write same word same cycle: read returns OLD data (read-first memory).
//  bd_we has priority over AXI writes (AXI write beat stalled, wready=0); reads unaffected.
//  Read and write channels fully independent; no ordering between them beyond read-first rule.
//  Reset mid-burst: both FSMs return idle next cycle; partial burst abandoned; written beats stay written.
// STRUCTURE
//  swarm package: axi_resp_t with AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10; AXI_SIZE_32B=3'b010.
//  Sub-module l1_bram: simple dual port (1 write w/ 4 byte enables, 1 read), sync read, read-first, MEM_WORDS deep.
//  Top holds the two FSMs, beat counters, error tracking, and backdoor arbitration.
// TESTING
//  Preload idx5=0x11; AR addr 0x14 len0 id1 -> rdata 0x11, rlast=1, rresp 00, rid 1, rvalid 2 cycles after AR.
//  Preload idx8..11=1,2,3,4; AR 0x20 len3, rready const 1 -> 4 beats back-to-back 1,2,3,4, rlast on 4th only.
//  Same burst with rready toggling 1,0,0,1... -> rdata stable during stalls, same sequence, no dropped/duplicated beat.
//  AW+W together addr 0x40 data 0xAABBCCDD strb 0101 over mem 0 -> B OKAY; readback 0x00BB00DD.
//  AR at MEM_WORDS*4-4 len1 -> beat0 OKAY, beat1 SLVERR data 0; AW out of range -> BRESP 10, memory unchanged.
//  Write and read to idx3 (old 7, new 9) same cycle -> read 7, next read 9; rstn pulse mid-read-burst -> rvalid 0, arready 1.

Source files
------------

// File: rtl/l1_axi_responder_pkg.sv
// l1_axi_responder shared types.
// AXI response codes, size encoding and FSM states.
package l1_axi_responder_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_SLVERR = 2'b10
  } axi_resp_t;

  localparam logic [2:0] AXI_SIZE_32B = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/l1_axi_responder_if.sv
// AXI4-subset bundle between an initiator and the L1 responder.
// master = initiator side, slave = responder side.
interface l1_axi_responder_if #(
  parameter int ID_WIDTH = 1
);
  logic                s_awvalid;
  logic                s_awready;
  logic [31:0]         s_awaddr;
  logic [7:0]          s_awlen;
  logic [2:0]          s_awsize;
  logic [ID_WIDTH-1:0] s_awid;
  logic                s_wvalid;
  logic                s_wready;
  logic [31:0]         s_wdata;
  logic [3:0]          s_wstrb;
  logic                s_wlast;
  logic                s_bvalid;
  logic                s_bready;
  logic [1:0]          s_bresp;
  logic [ID_WIDTH-1:0] s_bid;
  logic                s_arvalid;
  logic                s_arready;
  logic [31:0]         s_araddr;
  logic [7:0]          s_arlen;
  logic [2:0]          s_arsize;
  logic [ID_WIDTH-1:0] s_arid;
  logic                s_rvalid;
  logic                s_rready;
  logic [31:0]         s_rdata;
  logic                s_rlast;
  logic [1:0]          s_rresp;
  logic [ID_WIDTH-1:0] s_rid;

  modport slave (
    input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awid,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast,
    input  s_bready,
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arid,
    input  s_rready,
    output s_awready, s_wready,
    output s_bvalid, s_bresp, s_bid,
    output s_arready,
    output s_rvalid, s_rdata, s_rlast, s_rresp, s_rid
  );

  modport master (
    output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awid,
    output s_wvalid, s_wdata, s_wstrb, s_wlast,
    output s_bready,
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arid,
    output s_rready,
    input  s_awready, s_wready,
    input  s_bvalid, s_bresp, s_bid,
    input  s_arready,
    input  s_rvalid, s_rdata, s_rlast, s_rresp, s_rid
  );
endinterface

// File: rtl/l1_axi_responder_bram.sv
// Simple dual-port word memory with byte enables.
// Synchronous, read-first read port; read data held when re=0.
module l1_bram #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  // Read samples old contents; byte-lane writes land at the same edge.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/l1_axi_responder.sv
// AXI4-subset memory responder backing a 32-bit word L1.
// Independent read/write FSMs; backdoor preload wins the write port.
module l1_axi_responder
  import l1_axi_responder_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int ID_WIDTH  = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  l1_axi_responder_if.slave            axi,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [31:0]                  bd_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [30:0] LIMIT = 31'(MEM_WORDS);

  wstate_t ws_q, ws_d;
  logic [30:0] widx_q, widx_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic werr_q, werr_d;
  logic wsz_q, wsz_d;

  rstate_t rs_q, rs_d;
  logic [30:0] ridx_q, ridx_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic rsz_q, rsz_d;
  logic rerr_q, rerr_d;

  logic awready, wready, bvalid;
  logic ax_we, beat_err;
  logic [30:0] ax_idx;
  logic arready, rvalid, rlast;
  logic mem_we, mem_re;
  logic [3:0] mem_strb;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [31:0] mem_wdata, mem_rdata;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^{axi.s_awaddr[1:0], axi.s_araddr[1:0]};

  // Write FSM: AW + first W together, then data beats, then B.
  always_comb begin
    ws_d     = ws_q;
    widx_d   = widx_q;
    wcnt_d   = wcnt_q;
    wlen_d   = wlen_q;
    bid_d    = bid_q;
    werr_d   = werr_q;
    wsz_d    = wsz_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    ax_we    = 1'b0;
    beat_err = 1'b0;
    ax_idx   = widx_q;
    unique case (ws_q)
      W_IDLE: begin
        awready = axi.s_awvalid & axi.s_wvalid & ~bd_we;
        wready  = awready;
        ax_idx  = {1'b0, axi.s_awaddr[31:2]};
        if (awready) begin
          wsz_d    = axi.s_awsize != AXI_SIZE_32B;
          beat_err = wsz_d | (ax_idx >= LIMIT);
          ax_we    = ~beat_err;
          widx_d   = ax_idx + 31'd1;
          wcnt_d   = 9'd1;
          wlen_d   = axi.s_awlen;
          bid_d    = axi.s_awid;
          werr_d   = beat_err
                   | (axi.s_wlast & (axi.s_awlen != 8'd0));
          ws_d     = axi.s_wlast ? W_RESP : W_DATA;
        end
      end
      W_DATA: begin
        wready = ~bd_we;
        if (axi.s_wvalid & wready) begin
          beat_err = wsz_q | (widx_q >= LIMIT);
          ax_we    = ~beat_err;
          widx_d   = widx_q + 31'd1;
          wcnt_d   = wcnt_q + 9'd1;
          werr_d   = werr_q | beat_err
                   | (axi.s_wlast & (wcnt_q != {1'b0, wlen_q}));
          if (axi.s_wlast) ws_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (axi.s_bready) ws_d = W_IDLE;
      end
      default: ws_d = W_IDLE;
    endcase
  end

  // Read FSM: fetch one beat ahead so beats stream 1 per cycle.
  always_comb begin
    rs_d      = rs_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rid_d     = rid_q;
    rsz_d     = rsz_q;
    rerr_d    = rerr_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = ridx_q[AW-1:0];
    unique case (rs_q)
      R_IDLE: begin
        arready = 1'b1;
        if (axi.s_arvalid) begin
          ridx_d = {1'b0, axi.s_araddr[31:2]};
          rlen_d = axi.s_arlen;
          rid_d  = axi.s_arid;
          rsz_d  = axi.s_arsize != AXI_SIZE_32B;
          rs_d   = R_FETCH;
        end
      end
      R_FETCH: begin
        mem_re = 1'b1;
        rerr_d = rsz_q | (ridx_q >= LIMIT);
        ridx_d = ridx_q + 31'd1;
        rcnt_d = 8'd0;
        rs_d   = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = rcnt_q == rlen_q;
        if (axi.s_rready) begin
          if (rlast) begin
            rs_d = R_IDLE;
          end else begin
            mem_re = 1'b1;
            rerr_d = rsz_q | (ridx_q >= LIMIT);
            ridx_d = ridx_q + 31'd1;
            rcnt_d = rcnt_q + 8'd1;
          end
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // State and burst-tracking registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ws_q   <= W_IDLE;
      widx_q <= '0;
      wcnt_q <= '0;
      wlen_q <= '0;
      bid_q  <= '0;
      werr_q <= 1'b0;
      wsz_q  <= 1'b0;
      rs_q   <= R_IDLE;
      ridx_q <= '0;
      rlen_q <= '0;
      rcnt_q <= '0;
      rid_q  <= '0;
      rsz_q  <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      ws_q   <= ws_d;
      widx_q <= widx_d;
      wcnt_q <= wcnt_d;
      wlen_q <= wlen_d;
      bid_q  <= bid_d;
      werr_q <= werr_d;
      wsz_q  <= wsz_d;
      rs_q   <= rs_d;
      ridx_q <= ridx_d;
      rlen_q <= rlen_d;
      rcnt_q <= rcnt_d;
      rid_q  <= rid_d;
      rsz_q  <= rsz_d;
      rerr_q <= rerr_d;
    end
  end

  assign mem_we    = bd_we | ax_we;
  assign mem_waddr = bd_we ? bd_addr : ax_idx[AW-1:0];
  assign mem_strb  = bd_we ? 4'hF : axi.s_wstrb;
  assign mem_wdata = bd_we ? bd_data : axi.s_wdata;

  l1_bram #(.MEM_WORDS(MEM_WORDS)) u_bram (
    .clk  (clk),
    .we   (mem_we),
    .wstrb(mem_strb),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  assign axi.s_awready = awready;
  assign axi.s_wready  = wready;
  assign axi.s_bvalid  = bvalid;
  assign axi.s_bresp   = (bvalid & werr_q) ? AXI_RESP_SLVERR
                                           : AXI_RESP_OKAY;
  assign axi.s_bid     = bid_q;
  assign axi.s_arready = arready;
  assign axi.s_rvalid  = rvalid;
  assign axi.s_rdata   = rerr_q ? 32'h0 : mem_rdata;
  assign axi.s_rlast   = rlast;
  assign axi.s_rresp   = (rvalid & rerr_q) ? AXI_RESP_SLVERR
                                           : AXI_RESP_OKAY;
  assign axi.s_rid     = rid_q;
endmodule
